// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, datapath mux selects and FSM states.
package ctrl_pkg;

    typedef enum logic [2:0] {
        T0     = 3'd0,
        T1     = 3'd1,
        T2     = 3'd2,
        T3     = 3'd3,
        HALTED = 3'd4
    } state_t;

    // Opcodes are held 32 bits wide so they compare cleanly against any OPCODE_W.
    localparam logic [31:0] OP_LD   = 32'd0;
    localparam logic [31:0] OP_ST   = 32'd1;
    localparam logic [31:0] OP_MVNZ = 32'd2;
    localparam logic [31:0] OP_MV   = 32'd3;
    localparam logic [31:0] OP_MVI  = 32'd4;
    localparam logic [31:0] OP_ADD  = 32'd5;
    localparam logic [31:0] OP_SUB  = 32'd6;
    localparam logic [31:0] OP_OR   = 32'd7;
    localparam logic [31:0] OP_SLT  = 32'd8;
    localparam logic [31:0] OP_SLL  = 32'd9;
    localparam logic [31:0] OP_SRL  = 32'd10;
    localparam logic [31:0] OP_JMP  = 32'd11;
    localparam logic [31:0] OP_HALT = 32'd15;

    localparam logic [1:0] SEL_DIN = 2'b00;
    localparam logic [1:0] SEL_REG = 2'b01;
    localparam logic [1:0] SEL_PC  = 2'b10;
    localparam logic [1:0] SEL_G   = 2'b11;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational step decode: (state, instruction fields, handshakes) -> datapath controls
// plus the done / halt / stall hints the state register uses to pick the next step.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 3,
    parameter int NUM_REGS   = 7,
    parameter int OPCODE_W   = 4
) (
    input  state_t                state,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic [REG_ADDR_W-1:0] rx,
    input  logic [REG_ADDR_W-1:0] ry,
    input  logic                  g_nonzero,
    input  logic                  mem_ready,
    output logic                  ir_in,
    output logic                  addr_in,
    output logic                  dout_in,
    output logic                  mem_write,
    output logic                  g_in,
    output logic                  a_in,
    output logic                  incr_pc,
    output logic                  pc_in,
    output logic [1:0]            mux_sel,
    output logic [OPCODE_W-1:0]   alu_op,
    output logic [NUM_REGS-1:0]   reg_in,
    output logic [REG_ADDR_W-1:0] reg_out,
    output logic                  done,
    output logic                  halt_next,
    output logic                  stall,
    output logic                  busy,
    output logic                  halted,
    output logic                  illegal
);

    logic [31:0] op_v;
    logic [31:0] rx_v;
    logic        wr_en;
    logic        bad_op;

    assign op_v = 32'(opcode);
    assign rx_v = 32'(rx);

    always_comb begin
        ir_in     = 1'b0;
        addr_in   = 1'b0;
        dout_in   = 1'b0;
        mem_write = 1'b0;
        g_in      = 1'b0;
        a_in      = 1'b0;
        incr_pc   = 1'b0;
        pc_in     = 1'b0;
        mux_sel   = SEL_DIN;
        alu_op    = '0;
        reg_out   = '0;
        done      = 1'b0;
        halt_next = 1'b0;
        stall     = 1'b0;
        halted    = 1'b0;
        wr_en     = 1'b0;
        bad_op    = 1'b0;

        case (state)
            T0: begin
                ir_in   = 1'b1;
                incr_pc = 1'b1;
            end
            T1: begin
                case (op_v)
                    OP_ADD, OP_SUB, OP_OR, OP_SLT, OP_SLL, OP_SRL: begin
                        reg_out = rx;
                        mux_sel = SEL_REG;
                        a_in    = 1'b1;
                    end
                    OP_LD, OP_ST: begin
                        reg_out = ry;
                        mux_sel = SEL_REG;
                        addr_in = 1'b1;
                    end
                    OP_MV: begin
                        wr_en   = 1'b1;
                        reg_out = ry;
                        mux_sel = SEL_REG;
                        done    = 1'b1;
                    end
                    OP_MVNZ: begin
                        done = 1'b1;
                        if (g_nonzero) begin
                            wr_en   = 1'b1;
                            reg_out = ry;
                            mux_sel = SEL_REG;
                        end
                    end
                    OP_MVI: begin
                        mux_sel = SEL_PC;
                        addr_in = 1'b1;
                    end
                    OP_JMP: begin
                        reg_out = ry;
                        mux_sel = SEL_REG;
                        pc_in   = 1'b1;
                        done    = 1'b1;
                    end
                    OP_HALT: begin
                        done      = 1'b1;
                        halt_next = 1'b1;
                    end
                    default: begin
                        bad_op = 1'b1;
                        done   = 1'b1;
                    end
                endcase
            end
            T2: begin
                case (op_v)
                    OP_ADD, OP_SUB, OP_OR, OP_SLT, OP_SLL, OP_SRL: begin
                        reg_out = ry;
                        mux_sel = SEL_REG;
                        alu_op  = opcode;
                        g_in    = 1'b1;
                    end
                    OP_LD: begin
                        wr_en = mem_ready;
                        done  = mem_ready;
                        stall = ~mem_ready;
                    end
                    OP_ST: begin
                        reg_out   = rx;
                        mux_sel   = SEL_REG;
                        dout_in   = 1'b1;
                        mem_write = 1'b1;
                        done      = mem_ready;
                        stall     = ~mem_ready;
                    end
                    OP_MVI: begin
                        wr_en   = mem_ready;
                        incr_pc = mem_ready;
                        done    = mem_ready;
                        stall   = ~mem_ready;
                    end
                    // Not reachable for single-step opcodes; finishing keeps the FSM from wandering.
                    default: done = 1'b1;
                endcase
            end
            T3: begin
                case (op_v)
                    OP_ADD, OP_SUB, OP_OR, OP_SLT, OP_SLL, OP_SRL: begin
                        wr_en   = 1'b1;
                        mux_sel = SEL_G;
                        done    = 1'b1;
                    end
                    default: done = 1'b1;
                endcase
            end
            HALTED: halted = 1'b1;
            default: ;
        endcase

        // Out-of-range Rx suppresses the write but lets the instruction finish.
        reg_in = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_en && rx_v == 32'(i)) reg_in[i] = 1'b1;
        end
        illegal = bad_op | (wr_en && rx_v >= 32'(NUM_REGS));
    end

    assign busy = (state != T0) && (state != HALTED);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle processor control unit: holds the step register and applies the transition
// precedence; all datapath controls are decoded from state and IR by ctrl_decode.
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 3,
    parameter int NUM_REGS   = 7,
    parameter int OPCODE_W   = 4,
    parameter int IR_W       = OPCODE_W + 2*REG_ADDR_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  run,
    input  logic [IR_W-1:0]       ir,
    input  logic                  g_nonzero,
    input  logic                  mem_ready,
    output logic                  ir_in,
    output logic                  addr_in,
    output logic                  dout_in,
    output logic                  mem_write,
    output logic                  g_in,
    output logic                  a_in,
    output logic                  incr_pc,
    output logic                  pc_in,
    output logic [1:0]            mux_sel,
    output logic [OPCODE_W-1:0]   alu_op,
    output logic [NUM_REGS-1:0]   reg_in,
    output logic [REG_ADDR_W-1:0] reg_out,
    output logic                  done,
    output logic                  busy,
    output logic                  halted,
    output logic                  illegal
);

    state_t state;
    logic   halt_next;
    logic   stall;

    ctrl_decode #(
        .REG_ADDR_W (REG_ADDR_W),
        .NUM_REGS   (NUM_REGS),
        .OPCODE_W   (OPCODE_W)
    ) u_decode (
        .state     (state),
        .opcode    (ir[IR_W-1 -: OPCODE_W]),
        .rx        (ir[2*REG_ADDR_W-1 -: REG_ADDR_W]),
        .ry        (ir[REG_ADDR_W-1:0]),
        .g_nonzero (g_nonzero),
        .mem_ready (mem_ready),
        .ir_in     (ir_in),
        .addr_in   (addr_in),
        .dout_in   (dout_in),
        .mem_write (mem_write),
        .g_in      (g_in),
        .a_in      (a_in),
        .incr_pc   (incr_pc),
        .pc_in     (pc_in),
        .mux_sel   (mux_sel),
        .alu_op    (alu_op),
        .reg_in    (reg_in),
        .reg_out   (reg_out),
        .done      (done),
        .halt_next (halt_next),
        .stall     (stall),
        .busy      (busy),
        .halted    (halted),
        .illegal   (illegal)
    );

    // HALTED is sticky until reset; run is not consulted there.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= T0;
        end else if (run && state != HALTED) begin
            if (done) begin
                state <= halt_next ? HALTED : T0;
            end else if (!stall) begin
                case (state)
                    T0:      state <= T1;
                    T1:      state <= T2;
                    T2:      state <= T3;
                    default: state <= T0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: expected output vectors are queued as each step
// is driven and popped against the sampled DUT outputs mid-cycle.
module tb_multicycle_ctrl_fsm;

    typedef struct packed {
        logic       ir_in;
        logic       addr_in;
        logic       dout_in;
        logic       mem_write;
        logic       g_in;
        logic       a_in;
        logic       incr_pc;
        logic       pc_in;
        logic [1:0] mux_sel;
        logic [3:0] alu_op;
        logic [6:0] reg_in;
        logic [2:0] reg_out;
        logic       done;
        logic       busy;
        logic       halted;
        logic       illegal;
    } obs_t;

    logic       clock;
    logic       reset;
    logic       run;
    logic [9:0] ir;
    logic       g_nonzero;
    logic       mem_ready;
    logic       ir_in, addr_in, dout_in, mem_write, g_in, a_in, incr_pc, pc_in;
    logic [1:0] mux_sel;
    logic [3:0] alu_op;
    logic [6:0] reg_in;
    logic [2:0] reg_out;
    logic       done, busy, halted, illegal;

    int   vectors;
    int   miscompares;
    obs_t exp_q[$];

    multicycle_ctrl_fsm dut (
        .clock     (clock),
        .reset     (reset),
        .run       (run),
        .ir        (ir),
        .g_nonzero (g_nonzero),
        .mem_ready (mem_ready),
        .ir_in     (ir_in),
        .addr_in   (addr_in),
        .dout_in   (dout_in),
        .mem_write (mem_write),
        .g_in      (g_in),
        .a_in      (a_in),
        .incr_pc   (incr_pc),
        .pc_in     (pc_in),
        .mux_sel   (mux_sel),
        .alu_op    (alu_op),
        .reg_in    (reg_in),
        .reg_out   (reg_out),
        .done      (done),
        .busy      (busy),
        .halted    (halted),
        .illegal   (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input obs_t e);
        obs_t got;
        obs_t want;
        exp_q.push_back(e);
        #2;
        got  = '{ir_in, addr_in, dout_in, mem_write, g_in, a_in, incr_pc, pc_in,
                 mux_sel, alu_op, reg_in, reg_out, done, busy, halted, illegal};
        want = exp_q.pop_front();
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    localparam obs_t E_T0     = '{ir_in: 1'b1, incr_pc: 1'b1, default: '0};
    localparam obs_t E_HALTED = '{halted: 1'b1, default: '0};

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        run         = 1'b0;
        ir          = '0;
        g_nonzero   = 1'b0;
        mem_ready   = 1'b1;
        #1;
        chk("reset_t0", E_T0);
        tick();
        tick();
        reset = 1'b0;
        run   = 1'b1;

        // ADD R1,R2
        ir = 10'b0101_001_010;
        chk("add_t0", E_T0);
        tick();
        chk("add_t1", '{a_in: 1'b1, reg_out: 3'd1, mux_sel: 2'b01, busy: 1'b1, default: '0});
        tick();
        chk("add_t2", '{g_in: 1'b1, alu_op: 4'b0101, reg_out: 3'd2, mux_sel: 2'b01, busy: 1'b1, default: '0});
        tick();
        chk("add_t3", '{reg_in: 7'b0000010, mux_sel: 2'b11, done: 1'b1, busy: 1'b1, default: '0});
        tick();
        chk("add_back_t0", E_T0);

        // LD R3,[R4] with three wait states
        ir        = 10'b0000_011_100;
        mem_ready = 1'b0;
        tick();
        chk("ld_t1", '{addr_in: 1'b1, reg_out: 3'd4, mux_sel: 2'b01, busy: 1'b1, default: '0});
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ld_t2_wait", '{busy: 1'b1, default: '0});
        end
        mem_ready = 1'b1;
        chk("ld_t2_ready", '{reg_in: 7'b0001000, done: 1'b1, busy: 1'b1, default: '0});
        tick();
        chk("ld_back_t0", E_T0);

        // ST R1,[R2], one wait state
        ir        = 10'b0001_001_010;
        mem_ready = 1'b0;
        tick();
        chk("st_t1", '{addr_in: 1'b1, reg_out: 3'd2, mux_sel: 2'b01, busy: 1'b1, default: '0});
        tick();
        chk("st_t2_wait", '{dout_in: 1'b1, mem_write: 1'b1, reg_out: 3'd1, mux_sel: 2'b01, busy: 1'b1, default: '0});
        tick();
        mem_ready = 1'b1;
        chk("st_t2_ready", '{dout_in: 1'b1, mem_write: 1'b1, reg_out: 3'd1, mux_sel: 2'b01, done: 1'b1, busy: 1'b1, default: '0});
        tick();
        chk("st_back_t0", E_T0);

        // MVI R2
        ir = 10'b0100_010_000;
        tick();
        chk("mvi_t1", '{addr_in: 1'b1, mux_sel: 2'b10, busy: 1'b1, default: '0});
        tick();
        chk("mvi_t2", '{reg_in: 7'b0000100, incr_pc: 1'b1, done: 1'b1, busy: 1'b1, default: '0});
        tick();
        chk("mvi_back_t0", E_T0);

        // MVNZ R0,R5 with G zero, then nonzero
        ir        = 10'b0010_000_101;
        g_nonzero = 1'b0;
        tick();
        chk("mvnz_g0_t1", '{done: 1'b1, busy: 1'b1, default: '0});
        tick();
        g_nonzero = 1'b1;
        chk("mvnz_back_t0", E_T0);
        tick();
        chk("mvnz_g1_t1", '{reg_in: 7'b0000001, reg_out: 3'd5, mux_sel: 2'b01, done: 1'b1, busy: 1'b1, default: '0});
        tick();
        g_nonzero = 1'b0;

        // SUB R2,R3 with run dropped during T2
        ir = 10'b0110_010_011;
        chk("sub_t0", E_T0);
        tick();
        chk("sub_t1", '{a_in: 1'b1, reg_out: 3'd2, mux_sel: 2'b01, busy: 1'b1, default: '0});
        tick();
        run = 1'b0;
        chk("sub_t2", '{g_in: 1'b1, alu_op: 4'b0110, reg_out: 3'd3, mux_sel: 2'b01, busy: 1'b1, default: '0});
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("sub_t2_frozen", '{g_in: 1'b1, alu_op: 4'b0110, reg_out: 3'd3, mux_sel: 2'b01, busy: 1'b1, default: '0});
        end
        run = 1'b1;
        tick();
        chk("sub_t3", '{reg_in: 7'b0000100, mux_sel: 2'b11, done: 1'b1, busy: 1'b1, default: '0});
        tick();
        chk("sub_back_t0", E_T0);

        // Unknown opcode 1100 is a one-step NOP flagged illegal
        ir = 10'b1100_000_000;
        tick();
        chk("bad_op_t1", '{illegal: 1'b1, done: 1'b1, busy: 1'b1, default: '0});
        tick();
        chk("bad_op_back_t0", E_T0);

        // JMP R6
        ir = 10'b1011_000_110;
        tick();
        chk("jmp_t1", '{pc_in: 1'b1, reg_out: 3'd6, mux_sel: 2'b01, done: 1'b1, busy: 1'b1, default: '0});
        tick();

        // MV R7,R1: R7 is out of range for a 7-register file
        ir = 10'b0011_111_001;
        chk("mv_r7_t0", E_T0);
        tick();
        chk("mv_r7_t1", '{reg_out: 3'd1, mux_sel: 2'b01, done: 1'b1, illegal: 1'b1, busy: 1'b1, default: '0});
        tick();
        chk("mv_r7_back_t0", E_T0);

        // Reset in the middle of an ADD discards it
        ir = 10'b0101_001_010;
        tick();
        tick();
        chk("abort_add_t2", '{g_in: 1'b1, alu_op: 4'b0101, reg_out: 3'd2, mux_sel: 2'b01, busy: 1'b1, default: '0});
        reset = 1'b1;
        chk("abort_reset_t0", E_T0);
        tick();
        reset = 1'b0;

        // HALT sticks through run toggling until an async reset
        ir = 10'b1111_000_000;
        tick();
        chk("halt_t1", '{done: 1'b1, busy: 1'b1, default: '0});
        for (int i = 0; i < 10; i++) begin
            tick();
            run = i[0];
            chk("halted_hold", E_HALTED);
        end
        run   = 1'b1;
        reset = 1'b1;
        chk("halt_async_reset", E_T0);
        tick();
        reset = 1'b0;
        chk("post_reset_t0", E_T0);
        tick();
        chk("post_reset_halt_t1", '{done: 1'b1, busy: 1'b1, default: '0});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Parametrised control unit for the multi-cycle processor datapath.
- Sequences the T0..T3 steps of each instruction and drives the enables, mux select, ALU op and register one-hot/select lines.
- Adds over the previous generation:
  - configurable register-file size and opcode width;
  - memory wait-state handshake;
  - jump and halt instructions;
  - illegal-opcode flag;
  - clean reset/done priority.
- Sits between the instruction register (IR) and the datapath mux/ALU/register bank.

Parameters:
- REG_ADDR_W, 3, width of the Rx/Ry fields
- NUM_REGS, 7, number of general registers written via reg_in (must be <= 2**REG_ADDR_W)
- OPCODE_W, 4, opcode field width
- IR_W, OPCODE_W+2*REG_ADDR_W, instruction width; fields are {opcode, Rx, Ry}, MSB first

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous active-high reset
- run  in  1  step enable; the FSM advances only when high
- ir  in  IR_W  current instruction
- g_nonzero  in  1  OR-reduction of G (used by MVNZ)
- mem_ready  in  1  memory handshake: data valid / write accepted
- ir_in, addr_in, dout_in, mem_write, g_in, a_in, incr_pc, pc_in  out  1 each  datapath enables
- mux_sel  out  2  00 DIN, 01 register, 10 PC, 11 G
- alu_op  out  OPCODE_W  ALU operation (equals opcode during the ALU step, else 0)
- reg_in  out  NUM_REGS  one-hot register write enable
- reg_out  out  REG_ADDR_W  register read select
- done  out  1  high during the last step of an instruction
- busy  out  1  high while state != T0 and != HALTED
- halted  out  1  high in HALTED
- illegal  out  1  one-cycle flag for an unknown opcode (or Rx >= NUM_REGS on a write)

Behaviour:
- State register: T0, T1, T2, T3, HALTED.
  - Async reset -> T0. All outputs are combinational decodes of state+ir, so they take the T0 decode after reset.
  - Nothing is registered except state.
- Default value of every output in every state is 0 unless listed below.
- Transition precedence at a clock edge:
  1. reset;
  2. run=0 holds state;
  3. done=1 -> T0;
  4. memory stall holds state;
  5. otherwise step+1.
- T0: ir_in=1, incr_pc=1.
- T1 by opcode:
  - ALU ops (ADD 0101, SUB 0110, OR 0111, SLT 1000, SLL 1001, SRL 1010): reg_out=Rx, mux_sel=01, a_in=1.
  - LD 0000 / ST 0001: reg_out=Ry, mux_sel=01, addr_in=1.
  - MV 0011: reg_in[Rx]=1, reg_out=Ry, mux_sel=01, done=1.
  - MVNZ 0010: done=1. Only if g_nonzero=1: reg_in[Rx]=1, reg_out=Ry, mux_sel=01.
  - MVI 0100: mux_sel=10, addr_in=1.
  - JMP 1011: reg_out=Ry, mux_sel=01, pc_in=1, done=1.
  - HALT 1111: done=1; next state is HALTED instead of T0.
  - Other opcodes: illegal=1, done=1 (NOP).
- T2:
  - ALU ops: reg_out=Ry, mux_sel=01, alu_op=opcode, g_in=1.
  - LD: mux_sel=00 and reg_in[Rx]=mem_ready; done=mem_ready. Stalls in T2 while mem_ready=0.
  - ST: reg_out=Rx, mux_sel=01, dout_in=1, mem_write=1 held until mem_ready=1; done=mem_ready.
  - MVI: mux_sel=00, reg_in[Rx]=mem_ready, incr_pc=mem_ready, done=mem_ready.
- T3 (ALU ops): reg_in[Rx]=1, mux_sel=11, done=1.
- HALTED: all enables 0, halted=1. Leaves HALTED only on reset; run is ignored.
- Register index Rx >= NUM_REGS on a write step:
  - reg_in stays 0 and illegal=1 in that step;
  - the instruction still completes normally.
- run low mid-instruction: outputs keep the current step's decode; no step advances.
- Reset mid-instruction: immediate return to T0; any partial instruction is discarded.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode localparams (LD..SRL, JMP, HALT);
  - mux_sel codes (SEL_DIN, SEL_REG, SEL_PC, SEL_G);
  - state encodings.
- One sub-module, ctrl_decode: purely combinational (state, opcode, Rx, Ry, g_nonzero, mem_ready) -> output bundle and done/next-state hint.
- The top module keeps only the state register and the transition precedence.

Test Plan:
- Reset then run=1 with ir=ADD R1,R2 (0101_001_010): cycle 0 ir_in=incr_pc=1; cycle 1 a_in=1, reg_out=1; cycle 2 g_in=1, alu_op=0101, reg_out=2; cycle 3 reg_in=0000010, mux_sel=11, done=1; cycle 4 back in T0.
- LD R3,[R4] with mem_ready low for 3 cycles: the FSM holds T2 with reg_in=0 and done=0; on the mem_ready=1 cycle reg_in=0001000, done=1; next cycle is T0.
- MVNZ R0,R5 with g_nonzero=0 -> T1 has reg_in=0 and done=1. Repeat with g_nonzero=1 -> reg_in=0000001, reg_out=5.
- run toggled low during T2 of SUB for 2 cycles -> state and outputs frozen (g_in=1 held); the sequence resumes to T3 when run returns high.
- Opcode 1100 -> illegal=1 and done=1 in T1, then T0. Opcode HALT -> halted=1 and ignores run for 10 cycles; async reset mid-cycle -> T0 immediately, halted=0.
- JMP R6 -> T1 has pc_in=1, reg_out=6, mux_sel=01, done=1. MV R7,R1 with NUM_REGS=7 -> illegal=1 and reg_in=0.
